data_memory_dump_reader: RTL and testbench

//  Debug-side reader of the MIPS data memory. On a start request it sweeps every DRAM word

---
 rtl/data_memory_dump_reader_pkg.sv | 19 +
 rtl/data_memory_dump_reader_word_byte_serializer.sv | 44 ++++
 rtl/data_memory_dump_reader.sv | 90 +++++++++
 tb/tb_data_memory_dump_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_dump_reader_pkg.sv
// Shared definitions for the data-memory dump reader: FSM state encodings
// and a small width helper used to size counters.
package data_memory_dump_reader_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD    = 3'd1;
  localparam logic [STATE_W-1:0] ST_SEND    = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_TX = 3'd3;
  localparam logic [STATE_W-1:0] ST_NEXT    = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_memory_dump_reader_word_byte_serializer.sv
// Holds the word being dumped and hands it out one byte at a time, MSB first.
// The top byte of word_reg is always the byte currently offered to the UART.
module data_memory_dump_reader_word_byte_serializer
  import data_memory_dump_reader_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [NB_DATA-1:0] load_data,
  input  logic               shift,
  output logic [NB_BYTE-1:0] tx_byte,
  output logic               last
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int CNT_W          = cnt_width(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [NB_DATA-1:0] word_reg;
  logic [CNT_W-1:0]   byte_cnt;

  // Capture a fresh word, or move the next byte into the top slot.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: word_reg is a plain register, not a RAM, so it is reset to keep o_tx_data at 0.
      word_reg <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      word_reg <= load_data;
      byte_cnt <= '0;
    end else if (shift) begin
      word_reg <= word_reg << NB_BYTE;
      if (!last) byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  assign last    = (byte_cnt == LAST_BYTE);
  assign tx_byte = word_reg[NB_DATA-1 -: NB_BYTE];

endmodule

// File: rtl/data_memory_dump_reader.sv
// Debug-side sweep of the data memory: reads every word from address 0 up to
// RAM_DEPTH-1 and streams it MSB-first, one byte per UART transmission.
// All outputs are decoded from registered state only.
module data_memory_dump_reader
  import data_memory_dump_reader_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int RAM_DEPTH = 256,
  parameter int NB_BYTE   = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_mem_read_data,
  output logic [NB_DATA-1:0] o_mem_address,
  output logic               o_mem_read_enable,
  output logic               o_mem_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam int ADDR_W = cnt_width(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic [ADDR_W-1:0]  addr;
  logic               ser_load;
  logic               ser_shift;
  logic               ser_last;

  // Next-state decode; i_start and i_tx_done only matter in their own states.
  // NOTE: next_state gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (i_start) next_state = ST_LOAD;
      ST_LOAD:    next_state = ST_SEND;
      ST_SEND:    next_state = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) next_state = ser_last ? ST_NEXT : ST_SEND;
      ST_NEXT:    next_state = (addr == LAST_ADDR) ? ST_DONE : ST_LOAD;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  // Word address: cleared on a new dump, advanced between words, never wraps.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr <= '0;
    end else if (state == ST_IDLE && i_start) begin
      addr <= '0;
    end else if (state == ST_NEXT && addr != LAST_ADDR) begin
      addr <= addr + ADDR_W'(1);
    end
  end

  assign ser_load  = (state == ST_LOAD);
  assign ser_shift = (state == ST_WAIT_TX) && i_tx_done;

  data_memory_dump_reader_word_byte_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .clk       (i_clock),
    .rst_n     (i_reset_n),
    .load      (ser_load),
    .load_data (i_mem_read_data),
    .shift     (ser_shift),
    .tx_byte   (o_tx_data),
    .last      (ser_last)
  );

  assign o_mem_address     = NB_DATA'(addr);
  assign o_mem_read_enable = (state == ST_LOAD);
  assign o_mem_valid       = (state == ST_LOAD);
  assign o_tx_start        = (state == ST_SEND);
  assign o_busy            = (state != ST_IDLE);
  assign o_done            = (state == ST_DONE);

endmodule

// File: tb/tb_data_memory_dump_reader.sv
// Bench for data_memory_dump_reader: a 2-word instance for protocol checks and a
// 256-word instance for the full sweep. A scoreboard holds expected bytes and
// addresses, pushed when a dump is requested and popped as the DUT emits them.
module tb_data_memory_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic sel;          // 0: small instance active, 1: big instance active
  logic tx_done = 1'b0;
  bit   tx_hold = 1'b0;
  int   tx_cnt  = 0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_tx  = 0;
  int n_done = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int tx_cyc[$];
  logic [7:0] exp_bytes[$];
  int         exp_addrs[$];

  // Small instance
  logic        s_start, s_re, s_valid, s_tx_start, s_busy, s_done;
  logic [31:0] s_rd, s_addr;
  logic [7:0]  s_tx_data;
  // Big instance
  logic        b_start, b_re, b_valid, b_tx_start, b_busy, b_done;
  logic [31:0] b_rd, b_addr;
  logic [7:0]  b_tx_data;
  // Monitored (active instance)
  logic        m_re, m_valid, m_tx_start, m_busy, m_done;
  logic [31:0] m_addr;
  logic [7:0]  m_tx_data;

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b ^ 8'h5A, b + 8'd7};
  endfunction

  assign s_start = start & ~sel;
  assign b_start = start & sel;
  always_comb s_rd = s_addr[0] ? 32'h01020304 : 32'hDEADBEEF;
  always_comb b_rd = pat(int'(b_addr));

  assign m_re       = sel ? b_re       : s_re;
  assign m_valid    = sel ? b_valid    : s_valid;
  assign m_tx_start = sel ? b_tx_start : s_tx_start;
  assign m_busy     = sel ? b_busy     : s_busy;
  assign m_done     = sel ? b_done     : s_done;
  assign m_addr     = sel ? b_addr     : s_addr;
  assign m_tx_data  = sel ? b_tx_data  : s_tx_data;

  data_memory_dump_reader #(.NB_DATA(32), .RAM_DEPTH(2), .NB_BYTE(8)) dut_small (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(s_start), .i_mem_read_data(s_rd),
    .o_mem_address(s_addr), .o_mem_read_enable(s_re), .o_mem_valid(s_valid),
    .o_tx_data(s_tx_data), .o_tx_start(s_tx_start), .i_tx_done(tx_done),
    .o_busy(s_busy), .o_done(s_done)
  );

  data_memory_dump_reader #(.NB_DATA(32), .RAM_DEPTH(256), .NB_BYTE(8)) dut_big (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(b_start), .i_mem_read_data(b_rd),
    .o_mem_address(b_addr), .o_mem_read_enable(b_re), .o_mem_valid(b_valid),
    .o_tx_data(b_tx_data), .o_tx_start(b_tx_start), .i_tx_done(tx_done),
    .o_busy(b_busy), .o_done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // UART TX model: level-high done, or a single done pulse 3 cycles after start.
  always @(negedge clk) begin
    if (tx_hold) begin
      tx_done = 1'b1;
    end else begin
      tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end
      if (m_tx_start) tx_cnt = 3;
    end
  end

  // Output monitor: compares emitted bytes and read addresses against the scoreboard.
  always @(negedge clk) begin
    if (m_tx_start) begin
      n_tx++;
      tx_cyc.push_back(cyc);
      if (exp_bytes.size() == 0) check("tx_unexpected_byte", {24'd0, m_tx_data}, 32'hFFFF_FFFF);
      else check("tx_byte", {24'd0, m_tx_data}, {24'd0, exp_bytes.pop_front()});
    end
    if (m_re) begin
      check("mem_valid", {31'd0, m_valid}, 32'd1);
      if (exp_addrs.size() == 0) check("mem_unexpected_read", m_addr, 32'hFFFF_FFFF);
      else check("mem_address", m_addr, exp_addrs.pop_front());
    end
    if (m_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     {31'd0, m_busy},     32'd0);
    check({tag, "_done"},     {31'd0, m_done},     32'd0);
    check({tag, "_tx_start"}, {31'd0, m_tx_start}, 32'd0);
    check({tag, "_re"},       {31'd0, m_re},       32'd0);
    check({tag, "_valid"},    {31'd0, m_valid},    32'd0);
    check({tag, "_addr"},     m_addr,              32'd0);
    check({tag, "_tx_data"},  {24'd0, m_tx_data},  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    exp_bytes.delete();
    exp_addrs.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_word(input int a, input logic [31:0] w);
    exp_addrs.push_back(a);
    for (int k = 3; k >= 0; k--) exp_bytes.push_back(w[k*8 +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0 = n_done;
    int i  = 0;
    while (n_done == n0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (n_done == n0) check({tag, "_done_timeout"}, n_done - n0, 32'd1);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int i = 0;
    while (n_tx < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (n_tx < target) check("wait_tx_timeout", n_tx, target);
  endtask

  initial begin
    int t0, d0, b0;
    sel   = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;

    // Reset state.
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word dump, done pulses 3 cycles after each start.
    t0 = n_tx; d0 = n_done;
    push_word(0, 32'hDEADBEEF);
    push_word(1, 32'h01020304);
    pulse_start();
    wait_done("dump2", 300);
    repeat (5) @(posedge clk);
    check("dump2_tx_count",   n_tx - t0,          32'd8);
    check("dump2_done_count", n_done - d0,        32'd1);
    check("dump2_bytes_left", exp_bytes.size(),   32'd0);
    check("dump2_addrs_left", exp_addrs.size(),   32'd0);
    check("dump2_idle",       {31'd0, m_busy},    32'd0);

    // Start pulses in mid-dump are ignored and not queued.
    t0 = n_tx; d0 = n_done;
    push_word(0, 32'hDEADBEEF);
    push_word(1, 32'h01020304);
    pulse_start();
    repeat (5) @(posedge clk);
    pulse_start();
    #1 check("restart_busy", {31'd0, m_busy}, 32'd1);
    repeat (12) @(posedge clk);
    pulse_start();
    wait_done("restart", 300);
    repeat (8) @(posedge clk);
    check("restart_tx_count",   n_tx - t0,        32'd8);
    check("restart_done_count", n_done - d0,      32'd1);
    check("restart_bytes_left", exp_bytes.size(), 32'd0);

    // tx_done held high from reset: two cycles per byte, none skipped.
    tx_hold = 1'b1;
    do_reset();
    t0 = n_tx; d0 = n_done; b0 = tx_cyc.size();
    push_word(0, 32'hDEADBEEF);
    push_word(1, 32'h01020304);
    pulse_start();
    wait_done("hold", 100);
    repeat (3) @(posedge clk);
    check("hold_tx_count",    n_tx - t0,                    32'd8);
    check("hold_done_count",  n_done - d0,                  32'd1);
    check("hold_first_send",  tx_cyc[b0] - start_cyc,       32'd1);
    check("hold_gap_b0_b1",   tx_cyc[b0+1] - tx_cyc[b0],    32'd2);
    check("hold_gap_b2_b3",   tx_cyc[b0+3] - tx_cyc[b0+2],  32'd2);
    check("hold_gap_word",    tx_cyc[b0+4] - tx_cyc[b0+3],  32'd4);
    check("hold_done_cycle",  done_cyc - start_cyc + 1,     32'd21);
    check("hold_bytes_left",  exp_bytes.size(),             32'd0);

    // Reset after the second byte aborts; next start restarts at address 0.
    tx_hold = 1'b0;
    do_reset();
    t0 = n_tx;
    push_word(0, 32'hDEADBEEF);
    push_word(1, 32'h01020304);
    pulse_start();
    wait_tx(t0 + 2, 100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_bytes.delete();
    exp_addrs.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    t0 = n_tx; d0 = n_done;
    push_word(0, 32'hDEADBEEF);
    push_word(1, 32'h01020304);
    pulse_start();
    wait_done("after_reset", 300);
    repeat (5) @(posedge clk);
    check("after_reset_tx_count",   n_tx - t0,        32'd8);
    check("after_reset_done_count", n_done - d0,      32'd1);
    check("after_reset_bytes_left", exp_bytes.size(), 32'd0);

    // Full 256-word sweep with tx_done held high.
    sel     = 1'b1;
    tx_hold = 1'b1;
    do_reset();
    t0 = n_tx; d0 = n_done;
    for (int a = 0; a < 256; a++) push_word(a, pat(a));
    pulse_start();
    wait_done("full", 4000);
    repeat (5) @(posedge clk);
    check("full_tx_count",    n_tx - t0,                 32'd1024);
    check("full_done_count",  n_done - d0,               32'd1);
    check("full_done_cycle",  done_cyc - start_cyc + 1,  32'd2561);
    check("full_bytes_left",  exp_bytes.size(),          32'd0);
    check("full_addrs_left",  exp_addrs.size(),          32'd0);
    check("full_idle",        {31'd0, m_busy},           32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
